vga_scaled_controller: RTL and testbench

VGA_SCALED_CONTROLLER -- requirements
Module: vga_scaled_controller

---
 rtl/vga_scaled_controller.sv | 216 +++++++++++++++++++++
 tb/tb_vga_scaled_controller.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scaled_controller.sv
`default_nettype none
// ============================================================================
//  Module      : vga_scaled_controller
//  Description : VGA timing generator with downscaled fetch coordinates,
//                a LATENCY-deep sync/enable pipeline aligned to the source
//                pixel return, and built-in test patterns.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_scaled_controller #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter bit HS_POL      = 1'b0,
    parameter bit VS_POL      = 1'b0,
    parameter int COLOR_W     = 2,
    parameter int COORD_W     = 10,
    parameter int SCALE_SHIFT = 0,
    parameter int LATENCY     = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [1:0]         pattern_sel,
    input  logic [COLOR_W-1:0] red_in,
    input  logic [COLOR_W-1:0] green_in,
    input  logic [COLOR_W-1:0] blue_in,
    output logic [COORD_W-1:0] xcoor,
    output logic [COORD_W-1:0] ycoor,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               hs,
    output logic               vs,
    output logic               de,
    output logic               frame_start,
    output logic [COLOR_W-1:0] red_out,
    output logic [COLOR_W-1:0] green_out,
    output logic [COLOR_W-1:0] blue_out
);

    localparam logic [COORD_W-1:0] C_H_LAST   = COORD_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [COORD_W-1:0] C_V_LAST   = COORD_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [COORD_W-1:0] C_H_ACTIVE = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] C_V_ACTIVE = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] C_HS_START = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] C_HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] C_VS_START = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] C_VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam int                 C_BAR_W    = H_ACTIVE / 8;
    localparam logic [1:0]         C_SYNC_IDLE = {~HS_POL, ~VS_POL};

    logic [COORD_W-1:0] r_h;
    logic [COORD_W-1:0] r_v;
    logic               w_active;
    logic [COORD_W-1:0] w_xs;
    logic [COORD_W-1:0] w_ys;
    logic               w_hs_raw;
    logic               w_vs_raw;
    logic [1:0]         r_sync [LATENCY];
    logic               r_de   [LATENCY];
    logic               w_tap_de;
    logic [COORD_W-1:0] w_tap_x;
    logic [3:0]         w_tap_y;
    logic [2:0]         w_bar;
    logic [COLOR_W-1:0] w_r;
    logic [COLOR_W-1:0] w_g;
    logic [COLOR_W-1:0] w_b;
    logic [COLOR_W-1:0] r_red;
    logic [COLOR_W-1:0] r_green;
    logic [COLOR_W-1:0] r_blue;

    // Horizontal/vertical position counters; v advances on h wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            r_h <= '0;
            r_v <= '0;
        end else if (enable) begin
            if (r_h == C_H_LAST) begin
                r_h <= '0;
                r_v <= (r_v == C_V_LAST) ? '0 : r_v + COORD_W'(1);
            end else begin
                r_h <= r_h + COORD_W'(1);
            end
        end
    end

    assign w_active = (r_h < C_H_ACTIVE) && (r_v < C_V_ACTIVE);
    assign w_xs     = w_active ? (r_h >> SCALE_SHIFT) : '0;
    assign w_ys     = w_active ? (r_v >> SCALE_SHIFT) : '0;
    assign w_hs_raw = ((r_h >= C_HS_START) && (r_h < C_HS_END)) ? HS_POL : ~HS_POL;
    assign w_vs_raw = ((r_v >= C_VS_START) && (r_v < C_VS_END)) ? VS_POL : ~VS_POL;

    // Sync and display-enable delay line, frozen while enable is low
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_sync[i] <= C_SYNC_IDLE;
                r_de[i]   <= 1'b0;
            end
        end else if (enable) begin
            r_sync[0] <= {w_hs_raw, w_vs_raw};
            r_de[0]   <= w_active;
            for (int i = 1; i < LATENCY; i++) begin
                r_sync[i] <= r_sync[i-1];
                r_de[i]   <= r_de[i-1];
            end
        end
    end

    // Tap the position whose source pixel is arriving this cycle
    generate
        if (LATENCY == 1) begin : g_tap_direct
            assign w_tap_de = w_active;
            assign w_tap_x  = w_xs;
            assign w_tap_y  = w_ys[3:0];
        end else begin : g_tap_pipe
            logic [COORD_W-1:0] r_xp [LATENCY-1];
            logic [3:0]         r_yp [LATENCY-1];

            // Scaled coordinate delay line feeding the pattern generator
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < LATENCY - 1; i++) begin
                        r_xp[i] <= '0;
                        r_yp[i] <= '0;
                    end
                end else if (enable) begin
                    r_xp[0] <= w_xs;
                    r_yp[0] <= w_ys[3:0];
                    for (int i = 1; i < LATENCY - 1; i++) begin
                        r_xp[i] <= r_xp[i-1];
                        r_yp[i] <= r_yp[i-1];
                    end
                end
            end

            assign w_tap_de = r_de[LATENCY-2];
            assign w_tap_x  = r_xp[LATENCY-2];
            assign w_tap_y  = r_yp[LATENCY-2];
        end
    endgenerate

    // Bar index: number of bar boundaries at or left of the scaled x
    always_comb begin
        w_bar = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (w_tap_x >= COORD_W'(k * C_BAR_W)) begin
                w_bar = 3'(k);
            end
        end
    end

    // Pixel colour selection; blanked outside the active area
    always_comb begin
        w_r = '0;
        w_g = '0;
        w_b = '0;
        if (w_tap_de) begin
            case (pattern_sel)
                2'd0: begin
                    w_r = red_in;
                    w_g = green_in;
                    w_b = blue_in;
                end
                2'd1: begin
                    w_r = {COLOR_W{w_bar[2]}};
                    w_g = {COLOR_W{w_bar[1]}};
                    w_b = {COLOR_W{w_bar[0]}};
                end
                2'd2: begin
                    if ((w_tap_x[3:0] == 4'd0) || (w_tap_y == 4'd0)) begin
                        w_r = '1;
                        w_g = '1;
                        w_b = '1;
                    end
                end
                default: begin
                    w_r = '1;
                    w_g = '1;
                    w_b = '1;
                end
            endcase
        end
    end

    // Output pixel register, lands in step with the last delay stage
    always_ff @(posedge clk) begin
        if (rst) begin
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
        end else if (enable) begin
            r_red   <= w_r;
            r_green <= w_g;
            r_blue  <= w_b;
        end
    end

    assign x           = r_h;
    assign y           = r_v;
    assign xcoor       = w_xs;
    assign ycoor       = w_ys;
    assign frame_start = enable && !rst && (r_h == '0) && (r_v == '0);
    assign hs          = enable ? r_sync[LATENCY-1][1] : ~HS_POL;
    assign vs          = enable ? r_sync[LATENCY-1][0] : ~VS_POL;
    assign de          = enable && r_de[LATENCY-1];
    assign red_out     = enable ? r_red   : '0;
    assign green_out   = enable ? r_green : '0;
    assign blue_out    = enable ? r_blue  : '0;

endmodule
`default_nettype wire

// File: tb/tb_vga_scaled_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_scaled_controller
//  Description : Self-checking bench for vga_scaled_controller on a reduced
//                raster (24x12), plus a second instance with scaling.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_scaled_controller;

    localparam int HA = 16, HF = 2, HSY = 3, HB = 3;
    localparam int VA = 8,  VF = 1, VSY = 2, VB = 1;
    localparam int HT = HA + HF + HSY + HB;
    localparam int VT = VA + VF + VSY + VB;
    localparam int L  = 2;
    localparam int LS = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1;
    logic [1:0] pattern_sel = 2'd0;
    logic [1:0] red_in = 2'd0, green_in = 2'd0, blue_in = 2'd1;

    logic [9:0] xcoor, ycoor, x, y;
    logic       hs, vs, de, frame_start;
    logic [1:0] red_out, green_out, blue_out;

    logic [9:0] s_xcoor, s_ycoor, s_x, s_y;
    logic       s_hs, s_vs, s_de, s_fs;
    logic [1:0] s_r, s_g, s_b;

    always #5 clk = ~clk;

    vga_scaled_controller #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(2), .COORD_W(10),
        .SCALE_SHIFT(0), .LATENCY(L)
    ) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .pattern_sel(pattern_sel),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .xcoor(xcoor), .ycoor(ycoor), .x(x), .y(y),
        .hs(hs), .vs(vs), .de(de), .frame_start(frame_start),
        .red_out(red_out), .green_out(green_out), .blue_out(blue_out)
    );

    vga_scaled_controller #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(2), .COORD_W(10),
        .SCALE_SHIFT(1), .LATENCY(LS)
    ) u_scaled (
        .clk(clk), .rst(rst), .enable(enable), .pattern_sel(2'd2),
        .red_in(2'd0), .green_in(2'd0), .blue_in(2'd0),
        .xcoor(s_xcoor), .ycoor(s_ycoor), .x(s_x), .y(s_y),
        .hs(s_hs), .vs(s_vs), .de(s_de), .frame_start(s_fs),
        .red_out(s_r), .green_out(s_g), .blue_out(s_b)
    );

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] b;
    } out_t;

    typedef struct {
        bit         is_reset;
        bit         meas;
        logic       en;
        logic [1:0] pat;
        int         n;
    } phase_t;

    typedef struct {
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] b;
    } rgb_t;

    localparam int NPH = 11;
    phase_t ph [NPH];
    rgb_t   bar_tab [8];

    out_t qm[$];
    out_t qs[$];
    int   hs_fall[$], hs_rise[$], vs_fall[$], vs_rise[$], fs_at[$];
    int   de_cnt;
    logic prev_hs, prev_vs;
    bit   meas;

    int         n_tot = 0;
    int         n_bad = 0;
    int         mh, mv, cyc;
    logic [1:0] src_r = 2'd0, src_g = 2'd0;

    function automatic out_t idle_out();
        out_t o;
        o = '0;
        o.hs = 1'b1;
        o.vs = 1'b1;
        return o;
    endfunction

    function automatic out_t model(int h, int v, int pat, int sh);
        out_t o;
        int   xs, ys, bar;
        bit   act;
        o    = '0;
        act  = (h < HA) && (v < VA);
        o.hs = (h >= HA + HF && h < HA + HF + HSY) ? 1'b0 : 1'b1;
        o.vs = (v >= VA + VF && v < VA + VF + VSY) ? 1'b0 : 1'b1;
        o.de = act;
        if (act) begin
            xs = h >> sh;
            ys = v >> sh;
            case (pat)
                0: begin
                    o.r = 2'(xs % 4);
                    o.g = 2'(ys % 4);
                    o.b = 2'd1;
                end
                1: begin
                    bar = xs / (HA / 8);
                    o.r = bar_tab[bar].r;
                    o.g = bar_tab[bar].g;
                    o.b = bar_tab[bar].b;
                end
                2: begin
                    if (xs % 16 == 0 || ys % 16 == 0) begin
                        o.r = 2'd3; o.g = 2'd3; o.b = 2'd3;
                    end
                end
                default: begin
                    o.r = 2'd3; o.g = 2'd3; o.b = 2'd3;
                end
            endcase
        end
        return o;
    endfunction

    function automatic int qget(input int q[$], input int idx);
        return (idx < q.size()) ? q[idx] : -1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (h=%0d v=%0d t=%0t)", nm, act, exp, mh, mv, $time);
        end
    endtask

    task automatic chk_out(input string pre, input out_t a, input out_t e);
        chk({pre, "_hs"},  a.hs, e.hs);
        chk({pre, "_vs"},  a.vs, e.vs);
        chk({pre, "_de"},  a.de, e.de);
        chk({pre, "_rgb"}, {a.r, a.g, a.b}, {e.r, e.g, e.b});
    endtask

    task automatic do_reset(input int n, input logic en);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst    = 1'b1;
            enable = en;
            #1;
            if (i > 0) begin
                chk("rst_x", x, 0);
                chk("rst_y", y, 0);
                chk("rst_xcoor", xcoor, 0);
                chk("rst_ycoor", ycoor, 0);
                chk_out("rst", {hs, vs, de, red_out, green_out, blue_out}, idle_out());
                chk_out("rst_s", {s_hs, s_vs, s_de, s_r, s_g, s_b}, idle_out());
            end
        end
        mh = 0;
        mv = 0;
        cyc = 0;
        qm.delete();
        qs.delete();
        repeat (L)  qm.push_back(idle_out());
        repeat (LS) qs.push_back(idle_out());
        prev_hs = 1'b1;
        prev_vs = 1'b1;
    endtask

    task automatic step(input logic en, input logic [1:0] pat);
        out_t e;
        bit   act;
        @(negedge clk);
        rst         = 1'b0;
        enable      = en;
        pattern_sel = pat;
        red_in      = src_r;
        green_in    = src_g;
        #1;
        act = (mh < HA) && (mv < VA);
        chk("x", x, mh);
        chk("y", y, mv);
        chk("xcoor", xcoor, act ? mh : 0);
        chk("ycoor", ycoor, act ? mv : 0);
        chk("s_xcoor", s_xcoor, act ? (mh >> 1) : 0);
        chk("s_ycoor", s_ycoor, act ? (mv >> 1) : 0);
        if (en) begin
            chk("frame_start", frame_start, (mh == 0 && mv == 0));
            qm.push_back(model(mh, mv, pat, 0));
            qs.push_back(model(mh, mv, 2, 1));
            e = qm.pop_front();
            chk_out("pix", {hs, vs, de, red_out, green_out, blue_out}, e);
            e = qs.pop_front();
            chk_out("s_pix", {s_hs, s_vs, s_de, s_r, s_g, s_b}, e);
            if (meas) begin
                if (prev_hs && !hs) hs_fall.push_back(cyc);
                if (!prev_hs && hs) hs_rise.push_back(cyc);
                if (prev_vs && !vs) vs_fall.push_back(cyc);
                if (!prev_vs && vs) vs_rise.push_back(cyc);
                if (frame_start)    fs_at.push_back(cyc);
                if (de && cyc < HT * VT) de_cnt++;
            end
            prev_hs = hs;
            prev_vs = vs;
            src_r = act ? 2'(mh % 4) : 2'd0;
            src_g = act ? 2'(mv % 4) : 2'd0;
            cyc++;
            if (mh == HT - 1) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
        end else begin
            chk("hold_frame_start", frame_start, 0);
            chk_out("hold", {hs, vs, de, red_out, green_out, blue_out}, idle_out());
            chk_out("hold_s", {s_hs, s_vs, s_de, s_r, s_g, s_b}, idle_out());
        end
    endtask

    initial begin
        bar_tab[0] = '{2'd0, 2'd0, 2'd0};
        bar_tab[1] = '{2'd0, 2'd0, 2'd3};
        bar_tab[2] = '{2'd0, 2'd3, 2'd0};
        bar_tab[3] = '{2'd0, 2'd3, 2'd3};
        bar_tab[4] = '{2'd3, 2'd0, 2'd0};
        bar_tab[5] = '{2'd3, 2'd0, 2'd3};
        bar_tab[6] = '{2'd3, 2'd3, 2'd0};
        bar_tab[7] = '{2'd3, 2'd3, 2'd3};

        //             reset meas en    pat   cycles
        ph[0]  = '{1'b1, 1'b0, 1'b1, 2'd0, 3};
        ph[1]  = '{1'b0, 1'b1, 1'b1, 2'd0, 2 * HT * VT + 10};
        ph[2]  = '{1'b0, 1'b0, 1'b0, 2'd0, 10};
        ph[3]  = '{1'b0, 1'b0, 1'b1, 2'd0, HT * VT - 10};
        ph[4]  = '{1'b0, 1'b0, 1'b1, 2'd1, HT * VT};
        ph[5]  = '{1'b0, 1'b0, 1'b1, 2'd2, HT * VT};
        ph[6]  = '{1'b0, 1'b0, 1'b1, 2'd3, 150};
        ph[7]  = '{1'b1, 1'b0, 1'b1, 2'd0, 2};
        ph[8]  = '{1'b0, 1'b0, 1'b1, 2'd0, 300};
        ph[9]  = '{1'b1, 1'b0, 1'b0, 2'd0, 2};
        ph[10] = '{1'b0, 1'b0, 1'b1, 2'd3, 60};

        de_cnt = 0;
        meas   = 1'b0;

        for (int p = 0; p < NPH; p++) begin
            meas = ph[p].meas;
            if (ph[p].is_reset) begin
                do_reset(ph[p].n, ph[p].en);
            end else begin
                for (int i = 0; i < ph[p].n; i++) begin
                    step(ph[p].en, ph[p].pat);
                end
            end
            if (p == 1) begin
                chk("hs_first_fall", qget(hs_fall, 0), HA + HF + L);
                chk("hs_low_len", qget(hs_rise, 0) - qget(hs_fall, 0), HSY);
                chk("hs_period", qget(hs_fall, 1) - qget(hs_fall, 0), HT);
                chk("vs_first_fall", qget(vs_fall, 0), (VA + VF) * HT + L);
                chk("vs_low_len", qget(vs_rise, 0) - qget(vs_fall, 0), VSY * HT);
                chk("fs_first", qget(fs_at, 0), 0);
                chk("fs_period", qget(fs_at, 1) - qget(fs_at, 0), HT * VT);
                chk("de_per_frame", de_cnt, HA * VA);
            end
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
